sprite_layer: RTL and testbench
===============================

Name: sprite_layer

Overview:
- Parametrised successor of the fixed-bitmap pattern generator.
- Renders one runtime-loadable SPR_W x SPR_H monochrome sprite over a programmable background colour.
- Supports integer scaling (1x/2x/4x/8x), frame-synchronous position update and an optional autonomous bounce mode.
- Sits between the VGA timing generator (pos_x, pos_y, active, frame_start) and the colour output pins.

Parameters:
POS_W, 9, width of pixel coordinates
SCREEN_W, 400, visible width in pixels
SCREEN_H, 300, visible height in pixels
SPR_W, 8, sprite width in bitmap pixels
SPR_H, 8, sprite height in bitmap rows
COLOR_W, 1, bits per colour channel
STEP, 1, bounce displacement per frame, in pixels

Ports:
clk25MHz  in  1  pixel clock
rst  in  1  synchronous active-high reset
pos_x  in  POS_W  current pixel column
pos_y  in  POS_W  current pixel row
active  in  1  visible-area flag
frame_start  in  1  one-cycle pulse, first cycle of each frame
cfg_we  in  1  bitmap row write enable
cfg_addr  in  clog2(SPR_H)  bitmap row index
cfg_data  in  SPR_W  row bits; MSB = leftmost pixel
spr_x_in  in  POS_W  requested sprite X (static mode)
spr_y_in  in  POS_W  requested sprite Y (static mode)
scale_in  in  2  scale exponent: 0=1x, 1=2x, 2=4x, 3=8x
bounce_en  in  1  1 = autonomous bounce, 0 = static position
fg_color  in  3*COLOR_W  sprite colour {r,g,b}
bg_color  in  3*COLOR_W  background colour {r,g,b}
o_red  out  COLOR_W  red
o_green  out  COLOR_W  green
o_blue  out  COLOR_W  blue
o_hit  out  1  current output pixel is a set sprite pixel

Behaviour:
- Clock and reset: single clock clk25MHz; rst is synchronous and active-high.
- Reset state:
  - o_red, o_green, o_blue and o_hit = 0.
  - All bitmap rows = 0.
  - Shadow registers sx, sy, scale = 0.
  - Bounce direction dir_x = dir_y = + (increasing).
  - Pipeline valid bits cleared.
- Reset asserted mid-frame: outputs are 0 from the next cycle. The bitmap is lost and must be reloaded.
- Shadow registers: sx, sy and scale are updated only in a frame_start cycle, so position and scale never change mid-frame.
- Static mode (bounce_en=0):
  - sx <= spr_x_in, sy <= spr_y_in, scale <= scale_in.
  - dir_x and dir_y reset to +.
- Bounce mode (bounce_en=1): scale <= scale_in. For X, with w = SPR_W << scale:
  - If dir + and sx+STEP+w > SCREEN_W: sx <= SCREEN_W-w, dir_x <= -.
  - Else if dir - and sx < STEP: sx <= 0, dir_x <= +.
  - Else sx <= sx ± STEP.
  - Y is identical, using SPR_H and SCREEN_H.
  - Entering bounce mode continues from the current sx/sy.
- Pipeline: fixed latency of 2 cycles from inputs (pos_x, pos_y, active) to outputs.
- Stage 1, registered:
  - dx = pos_x - sx and dy = pos_y - sy, computed at POS_W+1 bits, unsigned compare.
  - inside = pos_x >= sx, pos_x < sx+(SPR_W<<scale), pos_y >= sy, pos_y < sy+(SPR_H<<scale).
  - col = dx >> scale, row = dy >> scale.
  - active delayed one stage.
- Stage 2, registered:
  - bit = bitmap[row][SPR_W-1-col].
  - o_hit = active_d2 & inside_d & bit.
  - Colour = o_hit ? fg_color : bg_color, gated to 0 when active_d2 = 0.
- Clipping: sprite area extending past SCREEN_W or SCREEN_H is simply never addressed. There is no wrap-around.
- Bitmap writes:
  - A write with cfg_we=1 takes effect at the clock edge.
  - A stage-2 read of the same row in the same cycle returns the old data (read-before-write).
  - Writes are allowed at any time, including mid-frame.
  - A cfg_addr >= SPR_H is ignored.
- Colour inputs fg_color and bg_color are sampled at stage 2 without a frame-sync shadow.

Test Plan:
- Reset and load: rst, load rows 0..7 = 0xFF, 0x81, 0x81, 0x81, 0x81, 0x81, 0x81, 0xFF; static mode with spr_x_in=10, spr_y_in=20, scale_in=0; fg=3'b100, bg=3'b001; pulse frame_start and scan.
  -> o_hit=1 exactly at the 28-pixel border of (10..17, 20..27).
  -> Interior pixels show blue; outputs lag pos by 2 cycles.
- Scale 2x (scale_in=1): same bitmap.
  -> Sprite covers x 10..25, y 20..35; pixel (11,21) is hit; pixel (12,22) is not hit.
- Frame-sync latch: change spr_x_in from 10 to 50 mid-frame.
  -> Current frame still draws at x=10; the next frame draws at x=50.
- Bounce, X axis: bounce_en=1, scale 0, start sx=390, SCREEN_W=400, STEP=1.
  -> Across frames sx = 391, 392, then clamps to 392 with dir -, then 391.
- Bounce, left/top edges: start sx=0, sy=0 with dir -.
  -> sx/sy hold at 0 and dir flips to +.
- Boundary cases:
  -> active=0 inside the sprite gives all outputs 0.
  -> A write to row 3 during a scan of row 3 shows the old bits in that cycle and the new bits from the next cycle.
  -> rst mid-line zeroes the outputs on the following cycle.

Source files
------------

// File: rtl/sprite_layer.sv
// rtl/sprite_layer.sv - scalable monochrome sprite overlay with frame-synced position and bounce
module sprite_layer #(
    parameter int POS_W    = 9,
    parameter int SCREEN_W = 400,
    parameter int SCREEN_H = 300,
    parameter int SPR_W    = 8,
    parameter int SPR_H    = 8,
    parameter int COLOR_W  = 1,
    parameter int STEP     = 1,
    localparam int AW      = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
    input  logic                 clk25MHz,
    input  logic                 rst,
    input  logic [POS_W-1:0]     pos_x,
    input  logic [POS_W-1:0]     pos_y,
    input  logic                 active,
    input  logic                 frame_start,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [SPR_W-1:0]     cfg_data,
    input  logic [POS_W-1:0]     spr_x_in,
    input  logic [POS_W-1:0]     spr_y_in,
    input  logic [1:0]           scale_in,
    input  logic                 bounce_en,
    input  logic [3*COLOR_W-1:0] fg_color,
    input  logic [3*COLOR_W-1:0] bg_color,
    output logic [COLOR_W-1:0]   o_red,
    output logic [COLOR_W-1:0]   o_green,
    output logic [COLOR_W-1:0]   o_blue,
    output logic                 o_hit
);
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int EW = POS_W + $clog2(SPR_W + SPR_H) + 4;

    // Returns {dir_neg, pos} after one bounce step along a single axis.
    function automatic logic [POS_W:0] bounce_step(
        input logic [POS_W-1:0] p,
        input logic             dir_neg,
        input logic [EW-1:0]    size,
        input logic [EW-1:0]    limit
    );
        logic [POS_W:0] r;
        if (!dir_neg && ((EW'(p) + EW'(STEP) + size) > limit)) begin
            r = {1'b1, POS_W'(limit - size)};
        end else if (dir_neg && (EW'(p) < EW'(STEP))) begin
            r = {1'b0, POS_W'(0)};
        end else if (dir_neg) begin
            r = {1'b1, p - POS_W'(STEP)};
        end else begin
            r = {1'b0, p + POS_W'(STEP)};
        end
        return r;
    endfunction

    logic [POS_W-1:0]     sx_q, sx_d, sy_q, sy_d;
    logic [1:0]           scale_q, scale_d;
    logic                 dir_x_neg_q, dir_x_neg_d, dir_y_neg_q, dir_y_neg_d;
    logic [EW-1:0]        new_w, new_h, cur_w, cur_h;
    logic [POS_W:0]       dx, dy;
    logic                 act1_q, act1_d, inside_q, inside_d;
    logic [AW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d, col_rev;
    logic [SPR_W-1:0]     bitmap_q [SPR_H];
    logic [SPR_W-1:0]     bitmap_d [SPR_H];
    logic [SPR_W-1:0]     row_bits;
    logic                 pix_bit, hit_q, hit_d;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;

    always_comb begin
        sx_d        = sx_q;
        sy_d        = sy_q;
        scale_d     = scale_q;
        dir_x_neg_d = dir_x_neg_q;
        dir_y_neg_d = dir_y_neg_q;
        new_w       = EW'(SPR_W) << scale_in;
        new_h       = EW'(SPR_H) << scale_in;
        if (frame_start) begin
            scale_d = scale_in;
            if (bounce_en) begin
                {dir_x_neg_d, sx_d} = bounce_step(sx_q, dir_x_neg_q, new_w, EW'(SCREEN_W));
                {dir_y_neg_d, sy_d} = bounce_step(sy_q, dir_y_neg_q, new_h, EW'(SCREEN_H));
            end else begin
                sx_d        = spr_x_in;
                sy_d        = spr_y_in;
                dir_x_neg_d = 1'b0;
                dir_y_neg_d = 1'b0;
            end
        end
    end

    // Stage 1: sprite-relative coordinates; a borrow in dx/dy means left of / above the sprite.
    always_comb begin
        cur_w    = EW'(SPR_W) << scale_q;
        cur_h    = EW'(SPR_H) << scale_q;
        dx       = {1'b0, pos_x} - {1'b0, sx_q};
        dy       = {1'b0, pos_y} - {1'b0, sy_q};
        inside_d = !dx[POS_W] && !dy[POS_W]
                && (EW'(pos_x) < (EW'(sx_q) + cur_w))
                && (EW'(pos_y) < (EW'(sy_q) + cur_h));
        col_d    = CW'(dx >> scale_q);
        row_d    = AW'(dy >> scale_q);
        act1_d   = active;
    end

    always_comb begin
        bitmap_d = bitmap_q;
        if (cfg_we && ({1'b0, cfg_addr} < (AW+1)'(SPR_H))) begin
            bitmap_d[cfg_addr] = cfg_data;
        end
    end

    // Stage 2: reads bitmap_q, so a same-cycle write to this row is seen one cycle later.
    always_comb begin
        row_bits = '0;
        if ({1'b0, row_q} < (AW+1)'(SPR_H)) begin
            row_bits = bitmap_q[row_q];
        end
        col_rev = CW'(SPR_W - 1) - col_q;
        pix_bit = row_bits[col_rev];
        hit_d   = act1_q & inside_q & pix_bit;
        rgb_d   = '0;
        if (act1_q) begin
            rgb_d = hit_d ? fg_color : bg_color;
        end
    end

    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            sx_q        <= '0;
            sy_q        <= '0;
            scale_q     <= '0;
            dir_x_neg_q <= 1'b0;
            dir_y_neg_q <= 1'b0;
            bitmap_q    <= '{default: '0};
            act1_q      <= 1'b0;
            inside_q    <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            hit_q       <= 1'b0;
            rgb_q       <= '0;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            scale_q     <= scale_d;
            dir_x_neg_q <= dir_x_neg_d;
            dir_y_neg_q <= dir_y_neg_d;
            bitmap_q    <= bitmap_d;
            act1_q      <= act1_d;
            inside_q    <= inside_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hit_q       <= hit_d;
            rgb_q       <= rgb_d;
        end
    end

    assign o_hit   = hit_q;
    assign o_red   = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign o_green = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign o_blue  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_sprite_layer.sv
// tb/tb_sprite_layer.sv - scoreboard bench for sprite_layer against a pixel-level reference model
module tb_sprite_layer;
    localparam int POS_W    = 9;
    localparam int SCREEN_W = 400;
    localparam int SCREEN_H = 300;
    localparam int SPR_W    = 8;
    localparam int SPR_H    = 8;
    localparam int STEP     = 1;

    logic       clk25MHz = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] pos_x = '0, pos_y = '0;
    logic       active = 1'b0, frame_start = 1'b0, cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic [8:0] spr_x_in = '0, spr_y_in = '0;
    logic [1:0] scale_in = '0;
    logic       bounce_en = 1'b0;
    logic [2:0] fg_color = '0, bg_color = '0;
    logic       o_red, o_green, o_blue, o_hit;

    sprite_layer #(
        .POS_W(POS_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
        .SPR_W(SPR_W), .SPR_H(SPR_H), .COLOR_W(1), .STEP(STEP)
    ) dut (
        .clk25MHz(clk25MHz), .rst(rst), .pos_x(pos_x), .pos_y(pos_y),
        .active(active), .frame_start(frame_start), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .spr_x_in(spr_x_in),
        .spr_y_in(spr_y_in), .scale_in(scale_in), .bounce_en(bounce_en),
        .fg_color(fg_color), .bg_color(bg_color), .o_red(o_red),
        .o_green(o_green), .o_blue(o_blue), .o_hit(o_hit)
    );

    always #20 clk25MHz = ~clk25MHz;

    // Reference state: sprite placement, bounce direction, bitmap, and the pixel held between stages.
    int         m_sx = 0, m_sy = 0, m_sc = 0;
    bit         m_xneg = 0, m_yneg = 0;
    logic [7:0] m_bmp [SPR_H];
    bit         p_act = 0, p_in = 0;
    int         p_row = 0, p_col = 0;
    logic [3:0] exp_q [$];
    int         vectors = 0, miscompares = 0;

    task automatic bounce(input int p, input bit neg, input int size, input int lim,
                          output int np, output bit nneg);
        if (!neg && p + STEP + size > lim) begin np = lim - size; nneg = 1; end
        else if (neg && p < STEP)          begin np = 0;          nneg = 0; end
        else if (neg)                      begin np = p - STEP;   nneg = 1; end
        else                               begin np = p + STEP;   nneg = 0; end
    endtask

    task automatic cycle();
        int px, py, sz, nx, ny;
        bit nxn, nyn;
        logic hit;
        logic [3:0] e;
        if (rst) e = '0;
        else begin
            hit = p_act && p_in && m_bmp[p_row][SPR_W-1-p_col];
            e = {hit, p_act ? (hit ? fg_color : bg_color) : 3'b000};
        end
        exp_q.push_back(e);
        if (rst) begin
            p_act = 0; p_in = 0;
        end else begin
            px = int'(pos_x); py = int'(pos_y); sz = 1 << m_sc;
            p_act = active;
            p_in = px >= m_sx && px < m_sx + SPR_W * sz && py >= m_sy && py < m_sy + SPR_H * sz;
            if (p_in) begin p_col = (px - m_sx) / sz; p_row = (py - m_sy) / sz; end
        end
        if (rst) begin
            m_sx = 0; m_sy = 0; m_sc = 0; m_xneg = 0; m_yneg = 0;
            for (int i = 0; i < SPR_H; i++) m_bmp[i] = '0;
        end else begin
            if (cfg_we && int'(cfg_addr) < SPR_H) m_bmp[cfg_addr] = cfg_data;
            if (frame_start) begin
                m_sc = int'(scale_in);
                if (!bounce_en) begin
                    m_sx = int'(spr_x_in); m_sy = int'(spr_y_in); m_xneg = 0; m_yneg = 0;
                end else begin
                    bounce(m_sx, m_xneg, SPR_W * (1 << m_sc), SCREEN_W, nx, nxn);
                    bounce(m_sy, m_yneg, SPR_H * (1 << m_sc), SCREEN_H, ny, nyn);
                    m_sx = nx; m_xneg = nxn; m_sy = ny; m_yneg = nyn;
                end
            end
        end
        @(negedge clk25MHz);
    endtask

    task automatic load_border();
        active = 0;
        for (int i = 0; i < SPR_H; i++) begin
            cfg_we = 1; cfg_addr = 3'(i);
            cfg_data = (i == 0 || i == SPR_H - 1) ? 8'hFF : 8'h81;
            cycle();
        end
        cfg_we = 0;
    endtask

    task automatic frame();
        frame_start = 1; active = 0; cycle(); frame_start = 0;
    endtask

    task automatic probe(input int x, input int y);
        pos_x = 9'(x); pos_y = 9'(y); active = 1; cycle();
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) probe(x, y);
    endtask

    task automatic edge_probes();
        int w, h;
        w = SPR_W << m_sc; h = SPR_H << m_sc;
        probe(m_sx - 1, m_sy); probe(m_sx, m_sy); probe(m_sx + w - 1, m_sy);
        probe(m_sx + w, m_sy); probe(m_sx, m_sy - 1); probe(m_sx, m_sy + h - 1);
        probe(m_sx, m_sy + h);
    endtask

    // Monitor: the output registered at each rising edge is checked shortly after it.
    initial begin
        logic [3:0] e, got;
        forever begin
            @(posedge clk25MHz); #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {o_hit, o_red, o_green, o_blue};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL pixel t=%0t got hit=%b rgb=%b want hit=%b rgb=%b",
                             $time, got[3], got[2:0], e[3], e[2:0]);
                end
            end
        end
    end

    initial begin
        @(negedge clk25MHz);
        rst = 1; repeat (3) cycle(); rst = 0;
        probe(12, 22);
        load_border();
        fg_color = 3'b100; bg_color = 3'b001;
        spr_x_in = 10; spr_y_in = 20; scale_in = 0; bounce_en = 0;
        frame();
        scan(6, 21, 18, 29);
        probe(12, 22); active = 0; cycle();
        pos_x = 12; pos_y = 20; active = 0; cycle();

        scale_in = 1; frame();
        scan(8, 27, 18, 37);
        probe(11, 21); probe(12, 22);

        scale_in = 0; frame();
        scan(6, 21, 18, 22);
        spr_x_in = 50;
        scan(6, 21, 23, 27);
        scan(46, 61, 20, 21);
        frame();
        scan(6, 21, 20, 21);
        scan(46, 61, 18, 29);

        spr_x_in = 10; frame();
        for (int x = 8; x <= 19; x++) begin
            pos_x = 9'(x); pos_y = 23; active = 1;
            cfg_we = 1; cfg_addr = 3; cfg_data = 8'($urandom);
            cycle();
        end
        cfg_we = 0; scan(8, 19, 23, 23);

        scan(8, 12, 20, 20);
        rst = 1; pos_x = 13; cycle(); rst = 0;
        scan(14, 18, 20, 21);
        load_border();

        for (int i = 0; i < 3000; i++) begin
            int w, h;
            w = SPR_W << m_sc; h = SPR_H << m_sc;
            pos_x = 9'(m_sx - 4 + int'($urandom_range(0, w + 8)));
            pos_y = 9'(m_sy - 4 + int'($urandom_range(0, h + 8)));
            active = ($urandom_range(0, 7) != 0);
            cfg_we = ($urandom_range(0, 15) == 0);
            cfg_addr = 3'($urandom); cfg_data = 8'($urandom);
            fg_color = 3'($urandom); bg_color = 3'($urandom);
            frame_start = ($urandom_range(0, 199) == 0);
            if (frame_start) begin
                spr_x_in = 9'($urandom); spr_y_in = 9'($urandom_range(0, 300));
                scale_in = 2'($urandom); bounce_en = ($urandom_range(0, 3) == 0);
            end
            cycle();
        end
        frame_start = 0; cfg_we = 0;
        fg_color = 3'b100; bg_color = 3'b001;

        bounce_en = 0; load_border();
        spr_x_in = 390; spr_y_in = 100; scale_in = 0; frame();
        edge_probes();
        bounce_en = 1;
        for (int f = 0; f < 6; f++) begin frame(); edge_probes(); end

        bounce_en = 0; spr_x_in = 336; spr_y_in = 236; scale_in = 3; frame();
        bounce_en = 1;
        for (int f = 0; f < 420; f++) begin frame(); edge_probes(); end

        active = 0; cycle(); cycle();
        @(posedge clk25MHz); #5;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
